rca_chunk_scheduler: RTL and testbench

- Shares one BITWIDTH-bit ripple-carry adder between NUM_REQ requesters.
- Each request is a wide add of W = BITWIDTH*NUM_CHUNKS bits. It is executed serially, one chunk per cycle, least-significant chunk first.
- Carry is passed between chunks through a registered carry bit.
- Sits between approximate-DNN accumulation units and a single area-cheap adder. It arbitrates, sequences chunks and returns results over a valid/ready response port.

---
 rtl/rca_chunk_scheduler_if.sv | 35 +++
 rtl/rca_chunk_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_rca_chunk_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca_chunk_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rca_chunk_scheduler_if                                         |
// | Brief   : Request/response bundle between requesters and the scheduler.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface rca_chunk_scheduler_if #(
  parameter int BITWIDTH   = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_REQ    = 2
);
  localparam int c_w    = BITWIDTH * NUM_CHUNKS;
  localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*c_w-1:0] req_a;
  logic [NUM_REQ*c_w-1:0] req_b;
  logic [NUM_REQ-1:0]     req_cin;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [c_id_w-1:0]      rsp_id;
  logic [c_w:0]           rsp_sum;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface
`default_nettype wire

// File: rtl/rca_chunk_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rca_chunk_scheduler                                            |
// | Brief   : Arbitrates NUM_REQ wide adds onto one BITWIDTH-bit adder, LSB  |
// |           chunk first. Define RCA_SCHED_FIXED_PRIO_EN for fixed priority.|
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rca_chunk_scheduler #(
  parameter int BITWIDTH   = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_REQ    = 2
) (
  input wire clk,
  input wire rst,
  rca_chunk_scheduler_if.slave bus
);
  localparam int c_w     = BITWIDTH * NUM_CHUNKS;
  localparam int c_id_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_cnt_w = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_w-1:0]      r_a;
  logic [c_w-1:0]      r_b;
  logic [c_w:0]        r_sum;
  logic                r_carry;
  logic [c_cnt_w-1:0]  r_k;
  logic [c_id_w-1:0]   r_id;

  logic                w_found;
  logic [c_id_w-1:0]   w_grant;
  logic                w_accept;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic [c_w-1:0]      w_a_sel;
  logic [c_w-1:0]      w_b_sel;
  logic                w_cin_sel;
  logic [BITWIDTH-1:0] w_a_chunk;
  logic [BITWIDTH-1:0] w_b_chunk;
  logic [BITWIDTH-1:0] w_chunk_sum;
  logic                w_cout;
  logic                w_last;

`ifdef RCA_SCHED_FIXED_PRIO_EN
  // Descending scan so the lowest-index valid requester is the last writer.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_found = 1'b1;
        w_grant = c_id_w'(i);
      end
    end
  end
`else
  logic [c_id_w-1:0] r_rr;
  logic              w_found_hi;
  logic              w_found_lo;
  logic [c_id_w-1:0] w_grant_hi;
  logic [c_id_w-1:0] w_grant_lo;

  // Requesters at or above the pointer beat the wrapped-around ones below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_grant_hi = '0;
    w_grant_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (c_id_w'(i) >= r_rr) begin
          w_found_hi = 1'b1;
          w_grant_hi = c_id_w'(i);
        end else begin
          w_found_lo = 1'b1;
          w_grant_lo = c_id_w'(i);
        end
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= (w_grant == c_id_w'(NUM_REQ - 1)) ? '0 : w_grant + c_id_w'(1);
    end
  end
`endif

  assign w_accept = (r_state == S_IDLE) && w_found && !rst;
  assign w_last   = (r_k == c_cnt_w'(NUM_CHUNKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !rst) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ready[i] = (w_grant == c_id_w'(i));
          end
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_cin_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == c_id_w'(i)) begin
        w_a_sel   = bus.req_a[i*c_w +: c_w];
        w_b_sel   = bus.req_b[i*c_w +: c_w];
        w_cin_sel = bus.req_cin[i];
      end
    end
  end

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int j = 0; j < NUM_CHUNKS; j++) begin
      if (r_k == c_cnt_w'(j)) begin
        w_a_chunk = r_a[j*BITWIDTH +: BITWIDTH];
        w_b_chunk = r_b[j*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // The single shared adder.
  assign {w_cout, w_chunk_sum} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                               + {{BITWIDTH{1'b0}}, r_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_id    <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= w_a_sel;
        r_b     <= w_b_sel;
        r_carry <= w_cin_sel;
        r_id    <= w_grant;
        r_k     <= '0;
      end
      if (r_state == S_RUN) begin
        for (int j = 0; j < NUM_CHUNKS; j++) begin
          if (r_k == c_cnt_w'(j)) begin
            r_sum[j*BITWIDTH +: BITWIDTH] <= w_chunk_sum;
          end
        end
        r_carry <= w_cout;
        if (w_last) begin
          r_sum[c_w] <= w_cout;
          r_k        <= '0;
        end else begin
          r_k <= r_k + c_cnt_w'(1);
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_rca_chunk_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rca_chunk_scheduler                                         |
// | Brief   : Directed self-checking bench for rca_chunk_scheduler.          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_rca_chunk_scheduler;
  localparam int BITWIDTH   = 8;
  localparam int NUM_CHUNKS = 4;
  localparam int NUM_REQ    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  rca_chunk_scheduler_if #(
    .BITWIDTH(BITWIDTH), .NUM_CHUNKS(NUM_CHUNKS), .NUM_REQ(NUM_REQ)
  ) bus ();

  rca_chunk_scheduler #(
    .BITWIDTH(BITWIDTH), .NUM_CHUNKS(NUM_CHUNKS), .NUM_REQ(NUM_REQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One isolated operation with rsp_ready held high; operands scrambled after accept.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [32:0] exp_sum);
    int lat;
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_cin[r]        = cin;
    bus.req_valid         = '0;
    bus.req_valid[r]      = 1'b1;
    bus.rsp_ready         = 1'b1;
    settle();
    chk("op_grant", 64'(bus.req_ready), 64'(1) << r);
    tick();
    bus.req_valid = '0;
    bus.req_a     = ~bus.req_a;
    bus.req_b     = ~bus.req_b;
    bus.req_cin   = ~bus.req_cin;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("op_latency", 64'(lat), 64'd5);
    chk("op_sum", 64'(bus.rsp_sum), 64'(exp_sum));
    chk("op_id", 64'(bus.rsp_id), 64'(r));
    tick();
    chk("op_rsp_clear", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[4];
    int acc_id[4];
    int exp_id[4];
    int n_acc;
    int n_rsp;
    int lat;
    int n_ghost;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    rst = 1'b0;
    tick();

    // Carry ripples through every chunk into bit W.
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
    run_op(1, 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 33'h0_2222_2221);

    // Both requesters continuously valid.
`ifdef RCA_SCHED_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    acc_cyc       = '{-1, -1, -1, -1};
    acc_id        = '{-1, -1, -1, -1};
    n_acc         = 0;
    n_rsp         = 0;
    bus.req_a     = {32'h0000_0100, 32'h0000_0001};
    bus.req_b     = {32'h0000_0200, 32'h0000_0002};
    bus.req_cin   = 2'b10;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      bus.req_valid = (n_acc < 4) ? 2'b11 : 2'b00;
      settle();
      if (bus.req_ready != '0) begin
        chk("rr_onehot", 64'($countones(bus.req_ready)), 64'd1);
        chk("rr_ready_in_done", 64'(bus.rsp_valid), 64'd0);
        if (n_acc < 4) begin
          acc_cyc[n_acc] = c;
          acc_id[n_acc]  = bus.req_ready[1] ? 1 : 0;
        end
        n_acc++;
      end
      if (bus.rsp_valid) begin
        if (n_rsp < 4) begin
          chk("rr_rsp_id", 64'(bus.rsp_id), 64'(exp_id[n_rsp]));
          chk("rr_rsp_sum", 64'(bus.rsp_sum), (exp_id[n_rsp] == 1) ? 64'h301 : 64'h3);
        end
        n_rsp++;
      end
      tick();
    end
    chk("rr_n_acc", 64'(n_acc), 64'd4);
    chk("rr_n_rsp", 64'(n_rsp), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", 64'(acc_id[k]), 64'(exp_id[k]));
      if (k > 0) chk("rr_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd6);
    end

    // Back-pressure in DONE while requester 1 waits.
    bus.req_a[31:0] = 32'hA5A5_A5A5;
    bus.req_b[31:0] = 32'h5A5A_5A5A;
    bus.req_cin[0]  = 1'b1;
    bus.req_valid   = 2'b01;
    bus.rsp_ready   = 1'b0;
    settle();
    chk("st_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 2'b10;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("st_latency", 64'(lat), 64'd5);
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("st_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.req_ready, bus.rsp_sum}),
          64'({1'b1, 1'b0, 2'b00, 33'h1_0000_0000}));
      tick();
    end
    bus.rsp_ready = 1'b1;
    settle();
    chk("st_rel_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("st_released", 64'(bus.rsp_valid), 64'd0);
    chk("st_idle_grant", 64'(bus.req_ready), 64'd2);
    bus.req_valid = '0;
    settle();

    // Reset during chunk 2 of an operation from requester 0.
    bus.req_a[31:0] = 32'h0000_0001;
    bus.req_b[31:0] = 32'h0000_0001;
    bus.req_cin[0]  = 1'b0;
    bus.req_valid   = 2'b01;
    settle();
    chk("ab_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("ab_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("ab_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    chk("ab_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("ab_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 2'b11;
    settle();
    chk("ab_rr_reset", 64'(bus.req_ready), 64'd1);
    bus.req_valid = '0;
    settle();
    n_ghost = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid) n_ghost++;
      tick();
    end
    chk("ab_no_rsp", 64'(n_ghost), 64'd0);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
